// File: rtl/register_file_if.sv
// Bus bundle for the register file: two combinational read ports and one synchronous write port.
// The master drives addresses and write data; the slave returns read data.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_s1;
    logic [ADDR_W-1:0] reg_s2;
    logic [ADDR_W-1:0] rd;
    logic              write_e;
    logic [DATA_W-1:0] write_d;
    logic [DATA_W-1:0] reg_d1;
    logic [DATA_W-1:0] reg_d2;

    modport master (
        output reg_s1, reg_s2, rd, write_e, write_d,
        input  reg_d1, reg_d2
    );

    modport slave (
        input  reg_s1, reg_s2, rd, write_e, write_d,
        output reg_d1, reg_d2
    );
endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file with x0 hardwired to zero.
// It has two independent combinational read ports and one write port.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    register_file_if.slave   bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_en_s;

    // Next-state for the array: only x[rd] may change, and never x0.
    always_comb begin
        regs_d  = regs_q;
        wr_en_s = bus.write_e && (bus.rd != {ADDR_W{1'b0}});
        if (wr_en_s) begin
            regs_d[bus.rd] = bus.write_d;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage: the async clear makes reads return zero the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports have no write bypass, so a same-cycle write is seen only after the edge.
    always_comb begin
        if (bus.reg_s1 == {ADDR_W{1'b0}}) begin
            bus.reg_d1 = {DATA_W{1'b0}};
        end else begin
            bus.reg_d1 = regs_q[bus.reg_s1];
        end
        if (bus.reg_s2 == {ADDR_W{1'b0}}) begin
            bus.reg_d2 = {DATA_W{1'b0}};
        end else begin
            bus.reg_d2 = regs_q[bus.reg_s2];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: writes, x0 behaviour,
// read-during-write, write disable, dual-port reads and asynchronous reset.
module tb_register_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a write at the falling edge, let one rising edge take it, then drop write_e.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.rd      = a;
        bus.write_d = d;
        bus.write_e = 1'b1;
        @(posedge clk);
        #1;
        bus.write_e = 1'b0;
    endtask

    task automatic set_reads(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        bus.reg_s1 = a1;
        bus.reg_s2 = a2;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.reg_s1   = 5'd0;
        bus.reg_s2   = 5'd0;
        bus.rd       = 5'd0;
        bus.write_e  = 1'b0;
        bus.write_d  = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        set_reads(5'd4, 5'd31);
        check_val("reset_d1_x4", bus.reg_d1, 32'd0);
        check_val("reset_d2_x31", bus.reg_d2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 42 to x4
        do_write(5'd4, 32'd42);
        set_reads(5'd4, 5'd0);
        check_val("wr42_d1_x4", bus.reg_d1, 32'd42);
        check_val("wr42_d2_x0", bus.reg_d2, 32'd0);

        // Write 99 to x2, x4 unchanged
        do_write(5'd2, 32'd99);
        set_reads(5'd2, 5'd4);
        check_val("wr99_d1_x2", bus.reg_d1, 32'd99);
        check_val("wr99_d2_x4", bus.reg_d2, 32'd42);

        // Read during write to the same address
        @(negedge clk);
        bus.reg_s1  = 5'd4;
        bus.rd      = 5'd4;
        bus.write_d = 32'd123;
        bus.write_e = 1'b1;
        #1;
        check_val("rdw_before", bus.reg_d1, 32'd42);
        @(posedge clk);
        #1;
        bus.write_e = 1'b0;
        check_val("rdw_after", bus.reg_d1, 32'd123);

        // Write to x0 ignored
        do_write(5'd0, 32'hDEADBEEF);
        set_reads(5'd0, 5'd0);
        check_val("x0_d1", bus.reg_d1, 32'd0);
        check_val("x0_d2", bus.reg_d2, 32'd0);

        // write_e=0 leaves x2 untouched
        @(negedge clk);
        bus.rd      = 5'd2;
        bus.write_d = 32'd7;
        bus.write_e = 1'b0;
        @(posedge clk);
        #1;
        set_reads(5'd2, 5'd2);
        check_val("we0_d1_x2", bus.reg_d1, 32'd99);
        check_val("we0_d2_x2", bus.reg_d2, 32'd99);

        // Both ports on the same register
        set_reads(5'd4, 5'd4);
        check_val("same_d1_x4", bus.reg_d1, 32'd123);
        check_val("same_d2_x4", bus.reg_d2, 32'd123);

        // Bit-exact storage at the top address and x1
        do_write(5'd31, 32'hFFFFFFFF);
        do_write(5'd1, 32'h80000001);
        set_reads(5'd31, 5'd1);
        check_val("exact_x31", bus.reg_d1, 32'hFFFFFFFF);
        check_val("exact_x1", bus.reg_d2, 32'h80000001);

        // Asynchronous reset between edges
        set_reads(5'd2, 5'd4);
        check_val("pre_rst_x2", bus.reg_d1, 32'd99);
        check_val("pre_rst_x4", bus.reg_d2, 32'd123);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_x2", bus.reg_d1, 32'd0);
        check_val("async_rst_x4", bus.reg_d2, 32'd0);

        // Write during reset is blocked
        bus.rd      = 5'd2;
        bus.write_d = 32'd55;
        bus.write_e = 1'b1;
        @(posedge clk);
        #1;
        check_val("wr_in_rst_x2", bus.reg_d1, 32'd0);
        bus.write_e = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        set_reads(5'd2, 5'd31);
        check_val("post_rst_x2", bus.reg_d1, 32'd0);
        check_val("post_rst_x31", bus.reg_d2, 32'd0);
        set_reads(5'd1, 5'd4);
        check_val("post_rst_x1", bus.reg_d1, 32'd0);
        check_val("post_rst_x4", bus.reg_d2, 32'd0);

        // First write after reset works normally
        do_write(5'd5, 32'h00001234);
        set_reads(5'd5, 5'd2);
        check_val("wr_after_rst_x5", bus.reg_d1, 32'h00001234);
        check_val("wr_after_rst_x2", bus.reg_d2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
